// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: one-cycle latency, load-use bubble insertion, flush/hold.
// Backpressure: stall_in freezes the register; stall_out asks PC and IF/ID to hold.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7b5,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_val,
  input  logic [XLEN-1:0]  id_rs2_val,
  input  logic [XLEN-1:0]  id_imm,
  input  logic             id_mem_rd,
  input  logic             id_mem_wr,
  input  logic             id_reg_wr,
  input  logic             id_mux_reg_wr,
  input  logic             id_jump,
  input  logic             id_branch,
  input  logic             id_jalr,
  input  logic [1:0]       id_ula_op,
  input  logic [1:0]       id_alu_src1,
  input  logic [1:0]       id_alu_src2,
  input  logic             flush,
  input  logic             stall_in,
  output logic             stall_out,
  output logic             ex_valid,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7b5,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_val,
  output logic [XLEN-1:0]  ex_rs2_val,
  output logic [XLEN-1:0]  ex_imm,
  output logic             ex_mem_rd,
  output logic             ex_mem_wr,
  output logic             ex_reg_wr,
  output logic             ex_mux_reg_wr,
  output logic             ex_jump,
  output logic             ex_branch,
  output logic             ex_jalr,
  output logic [1:0]       ex_ula_op,
  output logic [1:0]       ex_alu_src1,
  output logic [1:0]       ex_alu_src2,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;

  logic uses_rs1;
  logic uses_rs2;
  logic ld_use;
  logic do_bubble;
  logic do_load;

  always_comb begin
    uses_rs1 = !((id_opcode == OP_LUI) || (id_opcode == OP_AUIPC) || (id_opcode == OP_JAL));
    uses_rs2 = (id_opcode == OP_R) || (id_opcode == OP_S) || (id_opcode == OP_B);
    ld_use   = id_valid && ex_valid && ex_mem_rd && (ex_rd != 5'd0) && !flush &&
               ((uses_rs1 && (id_rs1 == ex_rd)) || (uses_rs2 && (id_rs2 == ex_rd)));
    // flush always wins; stall_in only defers a load-use bubble
    do_bubble = flush || (!stall_in && ld_use);
    do_load   = !flush && !stall_in && !ld_use;
  end

  assign stall_out = ld_use | stall_in;

  always_ff @(posedge clk) begin
    if (rst || do_bubble) begin
      ex_valid      <= 1'b0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_funct3     <= '0;
      ex_funct7b5   <= 1'b0;
      ex_pc         <= '0;
      ex_rs1_val    <= '0;
      ex_rs2_val    <= '0;
      ex_imm        <= '0;
      ex_mem_rd     <= 1'b0;
      ex_mem_wr     <= 1'b0;
      ex_reg_wr     <= 1'b0;
      ex_mux_reg_wr <= 1'b0;
      ex_jump       <= 1'b0;
      ex_branch     <= 1'b0;
      ex_jalr       <= 1'b0;
      ex_ula_op     <= '0;
      ex_alu_src1   <= '0;
      ex_alu_src2   <= '0;
    end else if (do_load) begin
      ex_valid      <= id_valid;
      ex_rs1        <= id_rs1;
      ex_rs2        <= id_rs2;
      ex_rd         <= id_rd;
      ex_funct3     <= id_funct3;
      ex_funct7b5   <= id_funct7b5;
      ex_pc         <= id_pc;
      ex_rs1_val    <= id_rs1_val;
      ex_rs2_val    <= id_rs2_val;
      ex_imm        <= id_imm;
      ex_mem_rd     <= id_mem_rd & id_valid;
      ex_mem_wr     <= id_mem_wr & id_valid;
      // branches, stores and x0 never write the register file
      ex_reg_wr     <= id_reg_wr & id_valid & (id_rd != 5'd0) & !id_branch & !id_mem_wr;
      ex_mux_reg_wr <= id_mux_reg_wr;
      ex_jump       <= id_jump;
      ex_branch     <= id_branch;
      ex_jalr       <= id_jalr;
      ex_ula_op     <= id_ula_op;
      ex_alu_src1   <= id_alu_src1;
      ex_alu_src2   <= id_alu_src2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (!stall_in && ld_use && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a rule-level model of the EX register.
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int CW   = 2;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_R = 7'b0110011, OP_I = 7'b0010011,
                         OP_S = 7'b0100011, OP_B = 7'b1100011, OP_LUI = 7'b0110111,
                         OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

  typedef struct packed {
    logic valid; logic [4:0] rs1, rs2, rd; logic [2:0] funct3; logic funct7b5;
    logic [31:0] pc, rs1_val, rs2_val, imm;
    logic mem_rd, mem_wr, reg_wr, mux_reg_wr, jump, branch, jalr;
    logic [1:0] ula_op, alu_src1, alu_src2;
  } ex_t;

  logic clk = 1'b0, rst = 1'b1;
  logic id_valid = 0; logic [6:0] id_opcode = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0; logic [2:0] id_funct3 = 0; logic id_funct7b5 = 0;
  logic [XLEN-1:0] id_pc = 0, id_rs1_val = 0, id_rs2_val = 0, id_imm = 0;
  logic id_mem_rd = 0, id_mem_wr = 0, id_reg_wr = 0, id_mux_reg_wr = 0;
  logic id_jump = 0, id_branch = 0, id_jalr = 0;
  logic [1:0] id_ula_op = 0, id_alu_src1 = 0, id_alu_src2 = 0;
  logic flush = 0, stall_in = 0, stall_out;
  logic ex_valid; logic [4:0] ex_rs1, ex_rs2, ex_rd; logic [2:0] ex_funct3; logic ex_funct7b5;
  logic [XLEN-1:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_mux_reg_wr, ex_jump, ex_branch, ex_jalr;
  logic [1:0] ex_ula_op, ex_alu_src1, ex_alu_src2;
  logic [CW-1:0] bubble_cnt;

  int checks = 0, failures = 0;
  ex_t obs, m_ex;
  int  m_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .id_pc(id_pc), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
    .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr), .id_reg_wr(id_reg_wr),
    .id_mux_reg_wr(id_mux_reg_wr), .id_jump(id_jump), .id_branch(id_branch), .id_jalr(id_jalr),
    .id_ula_op(id_ula_op), .id_alu_src1(id_alu_src1), .id_alu_src2(id_alu_src2),
    .flush(flush), .stall_in(stall_in), .stall_out(stall_out), .ex_valid(ex_valid),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_funct7b5(ex_funct7b5), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_imm(ex_imm), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_reg_wr(ex_reg_wr),
    .ex_mux_reg_wr(ex_mux_reg_wr), .ex_jump(ex_jump), .ex_branch(ex_branch), .ex_jalr(ex_jalr),
    .ex_ula_op(ex_ula_op), .ex_alu_src1(ex_alu_src1), .ex_alu_src2(ex_alu_src2),
    .bubble_cnt(bubble_cnt)
  );

  assign obs = {ex_valid, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5, ex_pc, ex_rs1_val,
                ex_rs2_val, ex_imm, ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_mux_reg_wr, ex_jump,
                ex_branch, ex_jalr, ex_ula_op, ex_alu_src1, ex_alu_src2};

  // Reference: an instruction reads rs1 unless LUI/AUIPC/JAL, reads rs2 only for R/S/B.
  function automatic logic model_hazard();
    logic u1, u2;
    u1 = !(id_opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
    u2 = id_opcode inside {OP_R, OP_S, OP_B};
    return id_valid && m_ex.valid && m_ex.mem_rd && (m_ex.rd != 0) && !flush &&
           ((u1 && id_rs1 == m_ex.rd) || (u2 && id_rs2 == m_ex.rd));
  endfunction

  function automatic ex_t model_from_id();
    ex_t e;
    e = '{valid: id_valid, rs1: id_rs1, rs2: id_rs2, rd: id_rd, funct3: id_funct3,
          funct7b5: id_funct7b5, pc: id_pc, rs1_val: id_rs1_val, rs2_val: id_rs2_val,
          imm: id_imm, mem_rd: id_mem_rd && id_valid, mem_wr: id_mem_wr && id_valid,
          reg_wr: id_reg_wr && id_valid && id_rd != 0 && !id_branch && !id_mem_wr,
          mux_reg_wr: id_mux_reg_wr, jump: id_jump, branch: id_branch, jalr: id_jalr,
          ula_op: id_ula_op, alu_src1: id_alu_src1, alu_src2: id_alu_src2};
    return e;
  endfunction

  // Advance the model by one edge, then let the DUT take the same edge.
  task automatic cycle();
    ex_t nx; int nc;
    nx = m_ex; nc = m_cnt;
    if (rst) begin nx = '0; nc = 0; end
    else if (flush) nx = '0;
    else if (stall_in) nx = m_ex;
    else if (model_hazard()) begin nx = '0; nc = (m_cnt == (1 << CW) - 1) ? m_cnt : m_cnt + 1; end
    else nx = model_from_id();
    @(posedge clk);
    m_ex = nx; m_cnt = nc;
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] r1,
                           input logic [4:0] r2);
    id_valid = 1; id_opcode = op; id_rd = rd; id_rs1 = r1; id_rs2 = r2;
    id_funct3 = 3'($urandom); id_funct7b5 = 1'($urandom);
    id_pc = $urandom; id_rs1_val = $urandom; id_rs2_val = $urandom; id_imm = $urandom;
    id_mem_rd = (op == OP_LOAD); id_mem_wr = (op == OP_S); id_branch = (op == OP_B);
    id_reg_wr = !(op == OP_S || op == OP_B); id_jump = (op == OP_JAL || op == OP_JALR);
    id_jalr = (op == OP_JALR); id_mux_reg_wr = (op == OP_LOAD);
    id_ula_op = 2'($urandom); id_alu_src1 = 2'($urandom); id_alu_src2 = 2'($urandom);
    flush = 0; stall_in = 0;
  endtask

  task automatic rand_id();
    logic [6:0] ops [9];
    ops = '{OP_LOAD, OP_R, OP_I, OP_S, OP_B, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
    set_instr(ops[$urandom_range(0, 8)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)));
    id_valid = ($urandom_range(0, 9) != 0);
    id_mem_rd = $urandom_range(0, 5) == 0 ? ~id_mem_rd : id_mem_rd;
    id_reg_wr = 1'($urandom); id_mem_wr = $urandom_range(0, 5) == 0 ? 1'b1 : id_mem_wr;
  endtask

  task automatic do_reset();
    rst = 1; rand_id(); cycle(); rand_id(); cycle(); rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; rand_id(); stall_in = 0; flush = 0;
    cycle(); rand_id(); cycle();
    checks++; if (obs !== '0) begin failures++; $display("FAIL reset_ex got=%h want=0", obs); end
    checks++; if (bubble_cnt !== 0) begin failures++; $display("FAIL reset_cnt got=%0d want=0", bubble_cnt); end
    rst = 0; set_instr(OP_R, 6, 5, 1); #1;
    checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b want=0", stall_out); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_instr(OP_LOAD, 5, 1, 0); cycle();
    set_instr(OP_R, 6, 5, 1); #1;
    checks++; if (stall_out !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b want=1", stall_out); end
    cycle();
    checks++; if (ex_valid !== 1'b0 || obs !== m_ex) begin failures++; $display("FAIL lu_bubble valid=%b want=0", ex_valid); end
    checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL lu_clear got=%b want=0", stall_out); end
    cycle();
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || obs !== m_ex) begin failures++; $display("FAIL lu_enter valid=%b rd=%0d want 1/6", ex_valid, ex_rd); end
    checks++; if (bubble_cnt !== 1) begin failures++; $display("FAIL lu_cnt got=%0d want=1", bubble_cnt); end
  endtask

  task automatic test_no_false_hazard();
    do_reset();
    set_instr(OP_LOAD, 0, 1, 0); cycle(); set_instr(OP_R, 6, 0, 0); #1;
    checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL nf_x0 got=%b want=0", stall_out); end
    set_instr(OP_LOAD, 5, 1, 0); cycle(); set_instr(OP_LUI, 5, 5, 5); #1;
    checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL nf_lui got=%b want=0", stall_out); end
    set_instr(OP_LOAD, 5, 1, 0); cycle(); set_instr(OP_I, 7, 1, 5); #1;
    checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL nf_addi got=%b want=0", stall_out); end
  endtask

  task automatic test_priority();
    ex_t snap; int c0;
    do_reset();
    set_instr(OP_LOAD, 5, 1, 0); cycle(); c0 = m_cnt;
    set_instr(OP_R, 6, 5, 1); flush = 1; stall_in = 1; #1;
    checks++; if (stall_out !== 1'b1) begin failures++; $display("FAIL pr_stall got=%b want=1", stall_out); end
    cycle();
    checks++; if (ex_valid !== 1'b0 || ex_mem_rd !== 1'b0 || bubble_cnt !== c0) begin failures++; $display("FAIL pr_flush valid=%b cnt=%0d want 0/%0d", ex_valid, bubble_cnt, c0); end
    set_instr(OP_LOAD, 5, 1, 0); cycle();
    set_instr(OP_R, 6, 5, 1); flush = 1; #1;
    checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL pr_flush_nostall got=%b want=0", stall_out); end
    cycle();
    set_instr(OP_I, 9, 2, 3); cycle(); snap = m_ex;
    for (int i = 0; i < 3; i++) begin
      rand_id(); stall_in = 1; flush = 0; cycle();
      checks++; if (obs !== snap) begin failures++; $display("FAIL pr_freeze%0d got=%h want=%h", i, obs, snap); end
    end
  endtask

  task automatic test_sanitize();
    do_reset();
    set_instr(OP_B, 4, 1, 2); id_reg_wr = 1; cycle();
    checks++; if (ex_reg_wr !== 1'b0) begin failures++; $display("FAIL san_beq got=%b want=0", ex_reg_wr); end
    set_instr(OP_I, 0, 1, 0); cycle();
    checks++; if (ex_reg_wr !== 1'b0) begin failures++; $display("FAIL san_x0 got=%b want=0", ex_reg_wr); end
    set_instr(OP_S, 0, 1, 2); id_valid = 0; cycle();
    checks++; if (ex_mem_wr !== 1'b0 || ex_valid !== 1'b0) begin failures++; $display("FAIL san_inv mem_wr=%b want=0", ex_mem_wr); end
    set_instr(OP_I, 8, 1, 0); cycle();
    checks++; if (ex_reg_wr !== 1'b1) begin failures++; $display("FAIL san_addi got=%b want=1", ex_reg_wr); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_instr(OP_LOAD, 5, 1, 0); cycle();
      set_instr(OP_R, 6, 5, 1); cycle(); cycle();
    end
    checks++; if (bubble_cnt !== 2'd3 || int'(bubble_cnt) !== m_cnt) begin failures++; $display("FAIL sat_cnt got=%0d want=3", bubble_cnt); end
  endtask

  task automatic test_random();
    logic exp_stall;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rand_id();
      flush = ($urandom_range(0, 9) == 0); stall_in = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 59) == 0);
      #1;
      exp_stall = model_hazard() || stall_in;
      checks++; if (!rst && stall_out !== exp_stall) begin failures++; $display("FAIL rnd_stall i=%0d got=%b want=%b", i, stall_out, exp_stall); end
      cycle();
      checks++; if (obs !== m_ex) begin failures++; $display("FAIL rnd_ex i=%0d got=%h want=%h", i, obs, m_ex); end
      checks++; if (int'(bubble_cnt) !== m_cnt) begin failures++; $display("FAIL rnd_cnt i=%0d got=%0d want=%0d", i, bubble_cnt, m_cnt); end
    end
    rst = 0;
  endtask

  initial begin
    m_ex = '0; m_cnt = 0;
    test_reset();
    test_load_use();
    test_no_false_hazard();
    test_priority();
    test_sanitize();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
